// File: rtl/acc_pkg.sv
// Shared types and constants for the bias-seeded accumulator sequencer.
package acc_pkg;

  localparam int DIN_W      = 20;
  localparam int B_W        = 8;
  localparam int ACC_W      = 22;
  localparam int N_TAPS_DEF = 4;
  localparam int CNT_W_DEF  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Requested run length limited to the number of taps the datapath can hold.
  function automatic int clamp_len(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/acc_beat_cnt.sv
// Beat counter for one accumulation run: counts accepted samples and flags
// the first and last beat against the latched run length.
module acc_beat_cnt
  import acc_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] len,
  output logic [CNT_W-1:0] cnt,
  output logic             first,
  output logic             last
);

  assign first = (cnt == '0);
  assign last  = (cnt == (len - CNT_W'(1)));

  // Count beats; wrap to zero after the last beat so the next run starts fresh.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || (inc && last)) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/acc_seq_ctrl.sv
// Sequencer for the bias-seeded accumulator datapath.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; cfg_len == 0 is rejected with an err pulse
//   ACCUM | accepting samples; bias seeds beat 0, dout captured on last
//   HOLD  | dout valid downstream; waits for out_ready, then IDLE/ACCUM
module acc_seq_ctrl
  import acc_pkg::*;
#(
  parameter int N_TAPS = N_TAPS_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sel,
  output logic             acc_we,
  output logic             en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             err
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] len_eff;
  logic [CNT_W-1:0] cnt;
  logic             cont_q;
  logic             err_q;
  logic             cnt_first;
  logic             cnt_last;
  logic             beat;
  logic             start_ok;
  logic             start_bad;

  assign len_eff   = CNT_W'(clamp_len(int'(cfg_len), N_TAPS));
  assign start_ok  = (state == IDLE) && start && (cfg_len != '0);
  assign start_bad = (state == IDLE) && start && (cfg_len == '0);
  assign beat      = (state == ACCUM) && in_valid;

  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign err       = err_q;

  acc_beat_cnt #(
    .CNT_W (CNT_W)
  ) u_beat_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_ok),
    .inc   (beat),
    .len   (len_q),
    .cnt   (cnt),
    .first (cnt_first),
    .last  (cnt_last)
  );

  // State register, run configuration latched at start, registered reject pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      len_q  <= '0;
      cont_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= start_bad;
      if (start_ok) begin
        len_q  <= len_eff;
        cont_q <= cont;
      end
    end
  end

  // Next state and datapath strobes; strobes are same-cycle with din and
  // stay low on stalled cycles so the accumulator holds its value.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    sel       = 1'b0;
    acc_we    = 1'b0;
    en        = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) state_nxt = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (beat) begin
          acc_we = 1'b1;
          sel    = cnt_first;
          en     = cnt_last;
          if (cnt_last) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_nxt = cont_q ? ACCUM : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
